// File: rtl/gb_frame_sequencer.sv
// APU frame sequencer: divides clk to the frame rate, walks the 8-step schedule and
// emits one-cycle length/sweep/envelope strobes plus the registered channel-1 trigger.
module gb_frame_sequencer #(
  parameter int PRESCALE_BITS = 13
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       apu_enable,
  input  logic       trigger_in,
  output logic       trigger,
  output logic       clk_length,
  output logic       clk_sweep,
  output logic       clk_envelope,
  output logic [2:0] step,
  output logic       length_skip
);

  localparam logic [PRESCALE_BITS-1:0] PRESCALE_ONE = 1;

  logic [PRESCALE_BITS-1:0] prescaler;
  logic                     pending;
  logic                     tick;
  logic                     sweep_due;
  logic                     defer;

  assign tick        = apu_enable && (&prescaler);
  assign sweep_due   = tick && ((step == 3'd2) || (step == 3'd6));
  // Trigger wins a collision; the sweep slips one cycle. A pending sweep never defers twice.
  assign defer       = sweep_due && trigger_in && !pending;
  assign length_skip = step[0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prescaler    <= '0;
      step         <= 3'd0;
      pending      <= 1'b0;
      trigger      <= 1'b0;
      clk_length   <= 1'b0;
      clk_sweep    <= 1'b0;
      clk_envelope <= 1'b0;
    end else if (!apu_enable) begin
      prescaler    <= '0;
      step         <= 3'd0;
      pending      <= 1'b0;
      trigger      <= 1'b0;
      clk_length   <= 1'b0;
      clk_sweep    <= 1'b0;
      clk_envelope <= 1'b0;
    end else begin
      prescaler    <= prescaler + PRESCALE_ONE;
      if (tick) begin
        step <= step + 3'd1;
      end
      pending      <= defer;
      trigger      <= trigger_in;
      clk_length   <= tick && !step[0];
      clk_sweep    <= (sweep_due || pending) && !defer;
      clk_envelope <= tick && (step == 3'd7);
    end
  end

endmodule

// File: tb/tb_gb_frame_sequencer.sv
// Randomized and directed bench for gb_frame_sequencer, checked against a frame-count model.
module tb_gb_frame_sequencer;

  localparam int PB    = 3;
  localparam int FRAME = 1 << PB;

  logic       clk = 1'b0;
  logic       reset;
  logic       apu_enable;
  logic       trigger_in;
  logic       trigger;
  logic       clk_length;
  logic       clk_sweep;
  logic       clk_envelope;
  logic [2:0] step;
  logic       length_skip;

  int total = 0;
  int bad   = 0;

  int       en_cycles = 0;
  bit       pend      = 1'b0;
  bit [7:0] exp_vec   = 8'd0;
  logic [7:0] dut_vec;

  gb_frame_sequencer #(.PRESCALE_BITS(PB)) dut (
    .clk          (clk),
    .reset        (reset),
    .apu_enable   (apu_enable),
    .trigger_in   (trigger_in),
    .trigger      (trigger),
    .clk_length   (clk_length),
    .clk_sweep    (clk_sweep),
    .clk_envelope (clk_envelope),
    .step         (step),
    .length_skip  (length_skip)
  );

  always #5 clk = ~clk;

  assign dut_vec = {trigger, clk_length, clk_sweep, clk_envelope, step, length_skip};

  // Expected outputs after one edge, from the count of enabled edges since (re)start.
  task automatic model_edge(input bit en, input bit tin);
    int s, ns;
    bit tk, len, env, due, sw;
    bit [2:0] ns3;
    if (!en) begin
      en_cycles = 0;
      pend      = 1'b0;
      exp_vec   = 8'd0;
    end else begin
      tk  = (en_cycles % FRAME) == FRAME - 1;
      s   = (en_cycles / FRAME) % 8;
      len = tk && (s % 2 == 0);
      env = tk && (s == 7);
      due = tk && (s == 2 || s == 6);
      if (due && tin && !pend) begin
        sw   = 1'b0;
        pend = 1'b1;
      end else begin
        sw   = due || pend;
        pend = 1'b0;
      end
      en_cycles++;
      ns      = (en_cycles / FRAME) % 8;
      ns3     = ns[2:0];
      exp_vec = {tin, len, sw, env, ns3, ns3[0]};
    end
  endtask

  task automatic model_reset();
    en_cycles = 0;
    pend      = 1'b0;
    exp_vec   = 8'd0;
  endtask

  task automatic drive(input bit en, input bit tin);
    apu_enable = en;
    trigger_in = tin;
    @(posedge clk);
    model_edge(en, tin);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; apu_enable = 1'b0; trigger_in = 1'b0;
    #3;
    total++;
    if (dut_vec !== 8'd0) begin bad++; $display("FAIL reset_state got=%b want=%b", dut_vec, 8'd0); end
    apu_enable = 1'b1; trigger_in = 1'b1;
    @(posedge clk); #1;
    total++;
    if (dut_vec !== 8'd0) begin bad++; $display("FAIL reset_hold got=%b want=%b", dut_vec, 8'd0); end
    apu_enable = 1'b0; trigger_in = 1'b0;
    #2 reset = 1'b0;
    model_reset();
  endtask

  task automatic test_schedule();
    int n_len = 0, n_sw = 0, n_env = 0, first_len = -1;
    for (int i = 1; i <= 16 * FRAME; i++) begin
      drive(1'b1, 1'b0);
      total++;
      if (dut_vec !== exp_vec) begin bad++; $display("FAIL schedule cyc=%0d got=%b want=%b", i, dut_vec, exp_vec); end
      if (clk_length === 1'b1 && first_len < 0) first_len = i;
      if (i <= 8 * FRAME) begin
        n_len += int'(clk_length === 1'b1);
        n_sw  += int'(clk_sweep === 1'b1);
        n_env += int'(clk_envelope === 1'b1);
      end
    end
    total++;
    if (first_len != FRAME) begin bad++; $display("FAIL first_length got=%0d want=%0d", first_len, FRAME); end
    total++;
    if (n_len != 4 || n_sw != 2 || n_env != 1) begin
      bad++; $display("FAIL strobe_counts got=%0d/%0d/%0d want=4/2/1", n_len, n_sw, n_env);
    end
  endtask

  task automatic test_collision();
    drive(1'b0, 1'b0);
    for (int i = 1; i < 3 * FRAME; i++) drive(1'b1, 1'b0);
    drive(1'b1, 1'b1);
    total++;
    if ({trigger, clk_length, clk_sweep} !== 3'b110) begin
      bad++; $display("FAIL collision_cycle got=%b want=110", {trigger, clk_length, clk_sweep});
    end
    drive(1'b1, 1'b0);
    total++;
    if ({trigger, clk_sweep} !== 2'b01) begin
      bad++; $display("FAIL deferred_sweep got=%b want=01", {trigger, clk_sweep});
    end
    // Step-6 sweep collides, then a second trigger lands on the deferred cycle.
    for (int i = 3 * FRAME + 2; i < 7 * FRAME; i++) drive(1'b1, 1'b0);
    drive(1'b1, 1'b1);
    total++;
    if (dut_vec !== exp_vec || clk_sweep !== 1'b0) begin
      bad++; $display("FAIL collision_step6 got=%b want=%b", dut_vec, exp_vec);
    end
    drive(1'b1, 1'b1);
    total++;
    if ({trigger, clk_sweep} !== 2'b11) begin
      bad++; $display("FAIL double_trigger got=%b want=11", {trigger, clk_sweep});
    end
  endtask

  task automatic test_disable();
    drive(1'b0, 1'b0);
    for (int i = 1; i <= 5 * FRAME + 2; i++) drive(1'b1, 1'b0);
    total++;
    if (step !== 3'd5) begin bad++; $display("FAIL pre_disable_step got=%0d want=5", step); end
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b1);
      total++;
      if (dut_vec !== 8'd0) begin bad++; $display("FAIL disabled_idle got=%b want=%b", dut_vec, 8'd0); end
    end
    for (int i = 1; i <= FRAME; i++) begin
      drive(1'b1, 1'b0);
      total++;
      if (dut_vec !== exp_vec) begin bad++; $display("FAIL reenable cyc=%0d got=%b want=%b", i, dut_vec, exp_vec); end
    end
    total++;
    if ({clk_length, clk_sweep, clk_envelope, step, length_skip} !== 7'b100_001_1) begin
      bad++; $display("FAIL reenable_step0 got=%b want=1000011", {clk_length, clk_sweep, clk_envelope, step, length_skip});
    end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 3 * FRAME + 3; i++) drive(1'b1, 1'b0);
    #2 reset = 1'b1;
    #1;
    model_reset();
    total++;
    if (dut_vec !== 8'd0) begin bad++; $display("FAIL async_reset got=%b want=%b", dut_vec, 8'd0); end
    @(posedge clk); #3;
    reset = 1'b0;
    for (int i = 1; i <= 10 * FRAME; i++) begin
      drive(1'b1, 1'b0);
      total++;
      if (dut_vec !== exp_vec) begin bad++; $display("FAIL post_reset cyc=%0d got=%b want=%b", i, dut_vec, exp_vec); end
    end
  endtask

  task automatic test_random();
    bit en, tin;
    for (int i = 0; i < 1500; i++) begin
      en  = ($urandom_range(0, 39) != 0);
      tin = ($urandom_range(0, 5) == 0);
      drive(en, tin);
      total++;
      if (dut_vec !== exp_vec) begin bad++; $display("FAIL random cyc=%0d got=%b want=%b", i, dut_vec, exp_vec); end
    end
  endtask

  initial begin
    test_reset();
    test_schedule();
    test_collision();
    test_disable();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
